// File: rtl/accel_axil_write_engine_if.sv
// accel_axil_write_engine_if
// AXI-Lite write-only channel bundle (AW, W, B). One instance carries the
// host-side slave traffic and another carries the frame-buffer master traffic.
interface accel_axil_write_engine_if #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   AWADDR;
    logic [2:0]              AWPROT;
    logic                    AWVALID;
    logic                    AWREADY;
    logic [DATA_WIDTH-1:0]   WDATA;
    logic [DATA_WIDTH/8-1:0] WSTRB;
    logic                    WVALID;
    logic                    WREADY;
    logic [1:0]              BRESP;
    logic                    BVALID;
    logic                    BREADY;

    modport master (
        output AWADDR, AWPROT, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WVALID,
        input  WREADY,
        input  BRESP, BVALID,
        output BREADY
    );

    modport slave (
        input  AWADDR, AWPROT, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WVALID,
        output WREADY,
        output BRESP, BVALID,
        input  BREADY
    );
endinterface

// File: rtl/accel_axil_write_engine.sv
// accel_axil_write_engine
// AXI-Lite write slave with a 4-word register file (CTRL, BASE, LEN, DATA)
// feeding a data FIFO, plus an AXI-Lite write master that drains the FIFO to
// BASE + i*(DATA_WIDTH/8) for LEN beats and raises RenderEndInterrupt at the
// end of the job.
// Optional feature macro: ACCEL_WSTRB_EN -- honour iWSTRB on CTRL/BASE/LEN
// writes and reject partial-strobe DATA pushes. Undefined: strobes ignored.
// Assumes ADDR_WIDTH >= 4 and FIFO_DEPTH a power of two >= 2.
module accel_axil_write_engine #(
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned OADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    accel_axil_write_engine_if.slave  host,
    accel_axil_write_engine_if.master fb,
    output logic                      RenderEndInterrupt
);

    localparam int unsigned BYTES = DATA_WIDTH / 8;
    localparam int unsigned PW    = $clog2(FIFO_DEPTH);

    localparam logic [ADDR_WIDTH-3:0] IDX_CTRL = (ADDR_WIDTH-2)'(0);
    localparam logic [ADDR_WIDTH-3:0] IDX_BASE = (ADDR_WIDTH-2)'(1);
    localparam logic [ADDR_WIDTH-3:0] IDX_LEN  = (ADDR_WIDTH-2)'(2);
    localparam logic [ADDR_WIDTH-3:0] IDX_DATA = (ADDR_WIDTH-2)'(3);
    localparam logic [PW:0]           CNT_FULL = (PW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_RESP} s_state_t;
    typedef enum logic [1:0] {M_IDLE, M_ADDR, M_RESP} m_state_t;

    s_state_t s_state;
    m_state_t m_state;

    // Register file and job state
    logic                  irq_en;
    logic                  irq_pending;
    logic                  busy;
    logic                  err;
    logic [DATA_WIDTH-1:0] base_reg;
    logic [DATA_WIDTH-1:0] len_reg;
    logic [DATA_WIDTH-1:0] job_base;
    logic [DATA_WIDTH-1:0] job_len;
    logic [DATA_WIDTH-1:0] idx;

    // Data FIFO
    logic [DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [PW:0]           count;
    logic                  fifo_full;
    logic                  fifo_empty;

    // Slave-side decode
    logic [DATA_WIDTH-1:0] byte_mask;
    logic                  data_strb_ok;
    logic [ADDR_WIDTH-3:0] reg_idx;
    logic                  s_hs;
    logic                  s_err;
    logic                  wr_go;
    logic                  ctrl_wr;
    logic                  base_wr;
    logic                  len_wr;
    logic                  data_wr;
    logic                  go_start;
    logic                  go_zero;
    logic                  irq_clr;

    // Master-side control
    logic                   m_pop;
    logic                   m_bdone;
    logic                   m_last;
    logic                   aw_done;
    logic                   w_done;
    logic                   aw_fin;
    logic                   w_fin;
    logic [OADDR_WIDTH-1:0] beat_addr;

`ifdef ACCEL_WSTRB_EN
    // Expand byte strobes into a bit mask; DATA pushes need every strobe set
    always_comb begin
        byte_mask = '0;
        for (int unsigned b = 0; b < BYTES; b++) begin
            byte_mask[b*8 +: 8] = {8{host.WSTRB[b]}};
        end
        data_strb_ok = &host.WSTRB;
    end
`else
    // Strobes ignored: every accepted write is a full-word write
    always_comb begin
        byte_mask    = '1;
        data_strb_ok = 1'b1;
    end
`endif

    // Decode the host write accepted this cycle and classify it OKAY/SLVERR
    always_comb begin
        reg_idx = host.AWADDR[ADDR_WIDTH-1:2];
        s_hs    = (s_state == S_ACC) && host.AWVALID && host.WVALID;
        wr_go   = host.WDATA[0] & byte_mask[0];
        s_err   = 1'b0;
        if (host.AWADDR[1:0] != 2'b00) begin
            s_err = 1'b1;
        end else if (reg_idx > IDX_DATA) begin
            s_err = 1'b1;
        end else if ((reg_idx == IDX_DATA) && (fifo_full || !data_strb_ok)) begin
            s_err = 1'b1;
        end else if ((reg_idx == IDX_CTRL) && wr_go && busy) begin
            s_err = 1'b1;
        end
        ctrl_wr  = s_hs && !s_err && (reg_idx == IDX_CTRL);
        base_wr  = s_hs && !s_err && (reg_idx == IDX_BASE);
        len_wr   = s_hs && !s_err && (reg_idx == IDX_LEN);
        data_wr  = s_hs && !s_err && (reg_idx == IDX_DATA);
        go_start = ctrl_wr && wr_go && (len_reg != '0);
        go_zero  = ctrl_wr && wr_go && (len_reg == '0);
        irq_clr  = ctrl_wr && host.WDATA[2] && byte_mask[2];
    end

    // Master-side status: FIFO level, beat launch, handshake completion
    always_comb begin
        fifo_full  = (count == CNT_FULL);
        fifo_empty = (count == '0);
        m_pop      = (m_state == M_IDLE) && busy && !fifo_empty;
        aw_fin     = aw_done || (fb.AWVALID && fb.AWREADY);
        w_fin      = w_done || (fb.WVALID && fb.WREADY);
        m_bdone    = (m_state == M_RESP) && fb.BVALID;
        m_last     = m_bdone && ((idx + DATA_WIDTH'(1)) == job_len);
        beat_addr  = OADDR_WIDTH'(job_base) + OADDR_WIDTH'(idx) * OADDR_WIDTH'(BYTES);
    end

    // Interrupt output gated by the enable bit
    always_comb begin
        RenderEndInterrupt = irq_pending & irq_en;
    end

    // Slave handshake FSM: open READYs, accept AW+W together, hold B until taken
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            s_state      <= S_IDLE;
            host.AWREADY <= 1'b0;
            host.WREADY  <= 1'b0;
            host.BVALID  <= 1'b0;
            host.BRESP   <= 2'b00;
        end else begin
            case (s_state)
                S_IDLE: begin
                    host.AWREADY <= 1'b1;
                    host.WREADY  <= 1'b1;
                    s_state      <= S_ACC;
                end
                S_ACC: begin
                    if (s_hs) begin
                        host.AWREADY <= 1'b0;
                        host.WREADY  <= 1'b0;
                        host.BVALID  <= 1'b1;
                        host.BRESP   <= s_err ? 2'b10 : 2'b00;
                        s_state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (host.BREADY) begin
                        host.BVALID <= 1'b0;
                        s_state     <= S_IDLE;
                    end
                end
                default: s_state <= S_IDLE;
            endcase
        end
    end

    // CTRL.IRQ_EN, BASE and LEN registers (byte-masked when strobes honoured)
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            irq_en   <= 1'b0;
            base_reg <= '0;
            len_reg  <= '0;
        end else begin
            if (ctrl_wr && byte_mask[1]) begin
                irq_en <= host.WDATA[1];
            end
            if (base_wr) begin
                base_reg <= (base_reg & ~byte_mask) | (host.WDATA & byte_mask);
            end
            if (len_wr) begin
                len_reg <= (len_reg & ~byte_mask) | (host.WDATA & byte_mask);
            end
        end
    end

    // FIFO storage; contents are don't-care while the pointers say empty
    always_ff @(posedge ACLK) begin
        if (data_wr) begin
            fifo_mem[wr_ptr] <= host.WDATA;
        end
    end

    // FIFO pointers and occupancy; full check already used the pre-pop count
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (data_wr) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (m_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({data_wr, m_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Job control: start on GO, advance per response, flag completion
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            busy        <= 1'b0;
            idx         <= '0;
            job_base    <= '0;
            job_len     <= '0;
            err         <= 1'b0;
            irq_pending <= 1'b0;
        end else begin
            if (go_start) begin
                busy     <= 1'b1;
                idx      <= '0;
                err      <= 1'b0;
                job_base <= base_reg;
                job_len  <= len_reg;
            end
            if (m_bdone) begin
                err <= err | (fb.BRESP != 2'b00);
                idx <= idx + DATA_WIDTH'(1);
                if (m_last) begin
                    busy <= 1'b0;
                end
            end
            // set and clear in the same cycle: set wins
            if (go_zero || m_last) begin
                irq_pending <= 1'b1;
            end else if (irq_clr) begin
                irq_pending <= 1'b0;
            end
        end
    end

    // Master beat FSM: load a beat, finish AW and W independently, await B
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            m_state    <= M_IDLE;
            fb.AWADDR  <= '0;
            fb.AWPROT  <= 3'b000;
            fb.AWVALID <= 1'b0;
            fb.WDATA   <= '0;
            fb.WSTRB   <= '0;
            fb.WVALID  <= 1'b0;
            fb.BREADY  <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            case (m_state)
                M_IDLE: begin
                    if (m_pop) begin
                        fb.AWADDR  <= beat_addr;
                        fb.AWPROT  <= 3'b010;
                        fb.AWVALID <= 1'b1;
                        fb.WDATA   <= fifo_mem[rd_ptr];
                        fb.WSTRB   <= '1;
                        fb.WVALID  <= 1'b1;
                        aw_done    <= 1'b0;
                        w_done     <= 1'b0;
                        m_state    <= M_ADDR;
                    end
                end
                M_ADDR: begin
                    if (fb.AWVALID && fb.AWREADY) begin
                        fb.AWVALID <= 1'b0;
                        aw_done    <= 1'b1;
                    end
                    if (fb.WVALID && fb.WREADY) begin
                        fb.WVALID <= 1'b0;
                        w_done    <= 1'b1;
                    end
                    if (aw_fin && w_fin) begin
                        fb.BREADY <= 1'b1;
                        m_state   <= M_RESP;
                    end
                end
                M_RESP: begin
                    if (fb.BVALID) begin
                        fb.BREADY <= 1'b0;
                        m_state   <= M_IDLE;
                    end
                end
                default: m_state <= M_IDLE;
            endcase
        end
    end

endmodule
